instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC control block. Consumes the word-aligned PC and fetches the instruction word over a req/gnt/rvalid instruction-memory handshake.
- Presents the fetched instruction to decode.
- Generates the stall that freezes the PC until the fetch completes and the rest of the core is ready.
- One outstanding request at a time; sized for the single-issue Eka core.

Parameters:
- ADDR_WIDTH, 32, byte-address width of instruction memory; PC input is ADDR_WIDTH-2 bits (word address).
- NOP_INSTR, 32'h0000_0013, word substituted for a faulted fetch (ADDI x0,x0,0).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- PC  in  ADDR_WIDTH-2  word address of next instruction, from PC control
- ext_stall  in  1  stall request from the rest of the core (data memory, hazards)
- stall  out  1  to PC control stall input; equals fetch_busy OR ext_stall
- imem_req  out  1  memory request valid
- imem_addr  out  ADDR_WIDTH  byte address {PC_latched, 2'b00}
- imem_gnt  in  1  memory accepted request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  read data
- imem_err  in  1  bus error, qualified by imem_rvalid
- instr  out  32  fetched instruction (registered)
- instr_pc  out  ADDR_WIDTH-2  word address instr came from
- instr_valid  out  1  instr/instr_pc hold a completed fetch for current PC
- instr_fault  out  1  current instr is NOP_INSTR due to imem_err

Behaviour:
- States: S_REQ, S_WAIT, S_DONE. Enum lives in the package.
- Reset (async, any state, mid-transaction included):
  - State goes to S_REQ.
  - imem_req=0 while reset is asserted.
  - instr=NOP_INSTR, instr_pc=0, instr_valid=0, instr_fault=0.
  - An in-flight response arriving after reset is dropped; rvalid is ignored outside S_WAIT.
- S_REQ:
  - imem_req=1, imem_addr={PC,2'b00}, fetch_busy=1.
  - PC is stable here because stall=1.
  - On imem_gnt: latch PC into instr_pc, go to S_WAIT. Otherwise stay, holding req and addr unchanged.
  - instr_valid=0.
- S_WAIT:
  - imem_req=0, fetch_busy=1.
  - On imem_rvalid: instr <= imem_err ? NOP_INSTR : imem_rdata; instr_fault <= imem_err; go to S_DONE.
  - rvalid in the same cycle as gnt is not legal; the memory returns data no earlier than one cycle after gnt.
- S_DONE:
  - instr_valid=1, fetch_busy=0, stall=ext_stall.
  - If ext_stall=0: PC control advances PC at this edge; next state is S_REQ and instr_valid drops next cycle.
  - If ext_stall=1: stay in S_DONE, holding instr, instr_pc and instr_fault.
- stall is combinational: (state!=S_DONE) | ext_stall. No other combinational path from memory inputs to stall.
- Throughput with zero-wait memory (gnt in the req cycle, rvalid next cycle): one instruction per 3 cycles. Each extra gnt or rvalid wait cycle adds exactly one cycle.
- Jumps and branches need no flush: PC only changes when leaving S_DONE, so every request uses the already-redirected PC.
- imem_addr lower 2 bits are always 0; PC wrap-around at the top of the address space is passed through unchanged.
- ext_stall while in S_REQ/S_WAIT does not affect the fetch; it only matters in S_DONE.

Decomposition:
- Package eka_fetch_pkg:
  - fetch_state_t enum {S_REQ, S_WAIT, S_DONE}
  - NOP_INSTR default constant
  - localparam for PC word width (ADDR_WIDTH-2)
- No sub-module. Single FSM plus output registers, roughly 150 lines.

Test Plan:
- Reset release with PC=0 and zero-wait memory (gnt in req cycle, rvalid next cycle, rdata=32'h00500093) -> imem_req=1 and imem_addr=0 in cycle 1; instr=32'h00500093, instr_valid=1, stall=0 in cycle 3; PC=1 is requested in cycle 4 (addr 0x4).
- gnt delayed 3 cycles with PC=0x10 -> imem_req and imem_addr=0x40 held constant all 4 cycles, stall=1 throughout, completion 3 cycles later than the zero-wait case.
- ext_stall=1 for 5 cycles while in S_DONE -> instr/instr_pc unchanged, instr_valid=1, stall=1, no new imem_req; request for the new PC issues the cycle after ext_stall drops.
- imem_rvalid with imem_err=1 -> instr=32'h00000013, instr_fault=1; next good fetch clears instr_fault=0.
- Async reset asserted in S_WAIT, then a stale rvalid with rdata=0xDEADBEEF after release -> stale data ignored, instr stays NOP_INSTR with instr_valid=0, fresh request issued at reset PC.
- Jump redirect (PC changes to 0x100 at the S_DONE edge) -> next imem_addr=0x400 and instr_pc=0x100 on completion.

Source files
------------

// File: rtl/eka_fetch_pkg.sv
// Shared types and defaults for the Eka instruction-fetch stage.
package eka_fetch_pkg;

    // Fetch sequencer: issue request, wait for data, hold result for decode
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } fetch_state_t;

    // ADDI x0,x0,0 - substituted for a fetch that returned a bus error
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // Byte-address width of instruction memory and the matching word-PC width
    localparam int unsigned ADDR_WIDTH_DEFAULT = 32;
    localparam int unsigned PC_WIDTH_DEFAULT   = ADDR_WIDTH_DEFAULT - 2;

endpackage

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: turns the word PC into a single outstanding
// req/gnt/rvalid instruction-memory transaction, registers the returned
// word for decode, and stalls PC control until the fetch has completed
// and the rest of the core is ready.
module instr_fetch
    import eka_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-3:0] PC,
    input  logic                  ext_stall,
    output logic                  stall,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [31:0]           imem_rdata,
    input  logic                  imem_err,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-3:0] instr_pc,
    output logic                  instr_valid,
    output logic                  instr_fault
);

    fetch_state_t state;
    logic         fetch_busy;

    // Sequencer plus result registers; rvalid is only honoured in S_WAIT,
    // so a response still in flight across a reset is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_REQ;
            instr       <= NOP_INSTR;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            instr_fault <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_gnt) begin
                        instr_pc <= PC;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instr       <= imem_err ? NOP_INSTR : imem_rdata;
                        instr_fault <= imem_err;
                        instr_valid <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    // PC control advances on this same edge when not stalled
                    if (!ext_stall) begin
                        instr_valid <= 1'b0;
                        state       <= S_REQ;
                    end
                end
                default: begin
                    instr_valid <= 1'b0;
                    state       <= S_REQ;
                end
            endcase
        end
    end

    // Request, address and stall decode; the request is gated by reset
    // because the sequencer already sits in S_REQ while reset is held.
    always_comb begin
        fetch_busy = (state != S_DONE);
        stall      = fetch_busy | ext_stall;
        imem_req   = (state == S_REQ) & ~reset;
        imem_addr  = {PC, 2'b00};
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a transaction-level model of the
// fetch stage, the PC control block and the instruction memory, compared
// against the DUT every cycle, plus hand-computed literal expectations.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [29:0] PC = '0;
    logic        ext_stall = 1'b0;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_err = 1'b0;
    logic [31:0] instr;
    logic [29:0] instr_pc;
    logic        instr_valid;
    logic        instr_fault;

    int checks = 0;
    int errors = 0;

    // Model of the fetch stage at handshake level
    logic        m_req   = 1'b1;   // a request for PC is outstanding on the bus
    logic        m_resp  = 1'b0;   // granted, awaiting read data
    logic        m_valid = 1'b0;   // a completed fetch is being presented
    logic [31:0] m_instr = NOP;
    logic [29:0] m_pc    = '0;
    logic        m_fault = 1'b0;

    // Memory / PC-control stimulus configuration
    int          cfg_gnt_dly = 0;
    int          cfg_rv_dly  = 0;
    logic        cfg_err     = 1'b0;
    int          gnt_cnt     = 0;
    int          rv_cnt      = 0;
    logic        stale_rv    = 1'b0;
    logic        jump_en     = 1'b0;
    logic [29:0] jump_pc     = '0;
    int          cyc;

    instr_fetch #(
        .ADDR_WIDTH(32),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .PC         (PC),
        .ext_stall  (ext_stall),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .imem_err   (imem_err),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_fault(instr_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // Instruction memory contents: word 0 is ADDI x1,x0,5
    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        if (wa == '0) return 32'h0050_0093;
        return {wa[15:0], ~wa[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
        end
    endtask

    // Full comparison of every DUT output against the model
    task automatic compare();
        logic exp_req;
        exp_req = m_req && !reset;
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, {PC, 2'b00});
        chk("stall", {31'b0, stall}, {31'b0, (!m_valid || ext_stall)});
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
        chk("instr", instr, m_instr);
        chk("instr_pc", {2'b0, instr_pc}, {2'b0, m_pc});
        chk("instr_fault", {31'b0, instr_fault}, {31'b0, m_fault});
    endtask

    task automatic sample();
        @(negedge clk);
        compare();
    endtask

    // Drive memory inputs for the coming edge, then advance model and PC
    task automatic advance();
        logic g, rv, er, leave_done;
        g  = m_req && !reset && (gnt_cnt >= cfg_gnt_dly);
        rv = (m_resp && !reset && (rv_cnt >= cfg_rv_dly)) || stale_rv;
        er = stale_rv ? 1'b0 : cfg_err;
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = stale_rv ? 32'hDEAD_BEEF : mem_word(m_pc);
        imem_err    = er;
        leave_done  = m_valid && !ext_stall && !reset;
        @(posedge clk);
        #1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_err    = 1'b0;
        imem_rdata  = '0;
        stale_rv    = 1'b0;
        if (!reset) begin
            if (g) begin
                m_req   = 1'b0;
                m_resp  = 1'b1;
                m_pc    = PC;
                gnt_cnt = 0;
                rv_cnt  = 0;
            end else if (m_req) begin
                gnt_cnt++;
            end else if (m_resp && rv) begin
                m_resp  = 1'b0;
                m_valid = 1'b1;
                m_instr = er ? NOP : mem_word(m_pc);
                m_fault = er;
            end else if (m_resp) begin
                rv_cnt++;
            end else if (leave_done) begin
                m_valid = 1'b0;
                m_req   = 1'b1;
                PC      = jump_en ? jump_pc : PC + 30'd1;
                jump_en = 1'b0;
            end
        end
    endtask

    task automatic leave();
        advance();
        sample();
    endtask

    task automatic model_reset();
        m_req = 1'b1; m_resp = 1'b0; m_valid = 1'b0;
        m_instr = NOP; m_pc = '0; m_fault = 1'b0;
        gnt_cnt = 0; rv_cnt = 0; jump_en = 1'b0;
        PC = '0;
    endtask

    // From a sampled request cycle, run until the model presents the result
    task automatic fetch_to_done(input int gd, input int rd, input logic err, output int n);
        cfg_gnt_dly = gd;
        cfg_rv_dly  = rd;
        cfg_err     = err;
        n = 0;
        while (!m_valid && n < 64) begin
            advance();
            sample();
            n++;
        end
        if (!m_valid) begin
            errors++;
            $display("FAIL fetch_timeout: got no completion, required completion within 64 cycles");
        end
    endtask

    initial begin
        // Power-on reset
        #1 reset = 1'b1;
        #1 model_reset();
        compare();
        repeat (2) begin advance(); sample(); end
        reset = 1'b0;
        #1 compare();

        // Zero-wait fetch of PC 0 right after reset
        sample();
        chk("c1_req", {31'b0, imem_req}, 32'd1);
        chk("c1_addr", imem_addr, 32'h0);
        fetch_to_done(0, 0, 1'b0, cyc);
        chk("zw_latency", cyc, 32'd2);
        chk("c3_instr", instr, 32'h0050_0093);
        chk("c3_valid", {31'b0, instr_valid}, 32'd1);
        chk("c3_stall", {31'b0, stall}, 32'd0);
        leave();
        chk("c4_req", {31'b0, imem_req}, 32'd1);
        chk("c4_addr", imem_addr, 32'h4);

        // Fetch PC 1, then redirect to 0x10
        fetch_to_done(0, 0, 1'b0, cyc);
        jump_en = 1'b1; jump_pc = 30'h10;
        leave();
        chk("j10_addr", imem_addr, 32'h40);

        // gnt delayed 3 cycles with ext_stall held (must not disturb the fetch)
        ext_stall = 1'b1;
        fetch_to_done(3, 0, 1'b0, cyc);
        chk("gd3_latency", cyc, 32'd5);
        chk("gd3_instr", instr, 32'h0010_FFEF);
        chk("gd3_pc", {2'b0, instr_pc}, 32'h10);

        // ext_stall held 5 cycles in the done state
        repeat (5) begin
            advance();
            sample();
            chk("es_valid", {31'b0, instr_valid}, 32'd1);
            chk("es_stall", {31'b0, stall}, 32'd1);
            chk("es_req", {31'b0, imem_req}, 32'd0);
            chk("es_instr", instr, 32'h0010_FFEF);
        end
        ext_stall = 1'b0;
        leave();
        chk("es_next_req", {31'b0, imem_req}, 32'd1);
        chk("es_next_addr", imem_addr, 32'h44);

        // Bus error response, then a clean fetch clears the fault
        fetch_to_done(0, 1, 1'b1, cyc);
        chk("err_latency", cyc, 32'd3);
        chk("err_instr", instr, 32'h0000_0013);
        chk("err_fault", {31'b0, instr_fault}, 32'd1);
        chk("err_pc", {2'b0, instr_pc}, 32'h11);
        leave();
        fetch_to_done(0, 0, 1'b0, cyc);
        chk("ok_fault", {31'b0, instr_fault}, 32'd0);
        chk("ok_instr", instr, 32'h0012_FFED);

        // Jump to 0x100 with mixed gnt and rvalid waits
        jump_en = 1'b1; jump_pc = 30'h100;
        leave();
        chk("j100_addr", imem_addr, 32'h400);
        fetch_to_done(1, 2, 1'b0, cyc);
        chk("j100_latency", cyc, 32'd5);
        chk("j100_pc", {2'b0, instr_pc}, 32'h100);

        // Top of address space and wrap-around
        jump_en = 1'b1; jump_pc = 30'h3FFF_FFFF;
        leave();
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        fetch_to_done(0, 0, 1'b0, cyc);
        leave();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_req", {31'b0, imem_req}, 32'd1);

        // Async reset while waiting for data, then a stale response
        cfg_gnt_dly = 0; cfg_rv_dly = 3; cfg_err = 1'b0;
        advance(); sample();
        advance(); sample();
        reset = 1'b1;
        #1 model_reset();
        compare();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        repeat (2) begin advance(); sample(); end
        reset = 1'b0;
        #1 compare();
        cfg_gnt_dly = 1;
        stale_rv = 1'b1;
        advance();
        sample();
        chk("stale_instr", instr, 32'h0000_0013);
        chk("stale_valid", {31'b0, instr_valid}, 32'd0);
        chk("stale_req", {31'b0, imem_req}, 32'd1);
        chk("stale_addr", imem_addr, 32'h0);
        fetch_to_done(1, 0, 1'b0, cyc);
        chk("post_rst_latency", cyc, 32'd2);
        chk("post_rst_instr", instr, 32'h0050_0093);
        chk("post_rst_pc", {2'b0, instr_pc}, 32'h0);
        leave();
        fetch_to_done(2, 1, 1'b0, cyc);
        leave();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
